ring_replay: RTL and testbench

RING_REPLAY -- requirements
Module: ring_replay

---
 rtl/ring_replay.sv | 205 ++++++++++++++++++++
 tb/tb_ring_replay.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_replay.sv
// Record-then-loop sample buffer: writes append to a RAM, the stored samples are replayed cyclically.
// Optional 16-bit replay-pass counter output (loop_cnt) enabled by defining RING_REPLAY_LOOPCNT_EN.
module ring_replay #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   length,
    output logic              full,
`ifdef RING_REPLAY_LOOPCNT_EN
    output logic [15:0]       loop_cnt,
`endif
    output logic              overflow
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              pend_q, pend_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              valid_q, valid_d;
    logic              full_s, wr_acc_s, pop_s, push_s, issue_s, wrap_s;
    logic [1:0]        occ_pop_s;

    assign full_s    = (len_q == DEPTH_L);
    assign wr_acc_s  = wr_en && !clear && !full_s;
    assign pop_s     = valid_q && m_ready;
    assign push_s    = pend_q;
    assign occ_pop_s = occ_q - {1'b0, pop_s};
    assign wrap_s    = (({1'b0, rd_ptr_q} + (ADDR_W+1)'(1)) == len_q);
    // Only issue a read if its data will have a free buffer slot when it lands.
    assign issue_s   = (state_q != IDLE) && !clear && !wr_acc_s &&
                       (({1'b0, occ_pop_s} + {2'b00, pend_q}) <= 3'd1);

    assign m_data   = buf0_q;
    assign m_valid  = valid_q;
    assign length   = len_q;
    assign full     = full_s;
    assign overflow = ovf_q;

    // Sample RAM: write at the current length, synchronous read of the replay pointer.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[len_q[ADDR_W-1:0]] <= din;
        end
        rd_q <= mem[rd_ptr_q];
    end

    // Next-state logic: clear beats write, an accepted write flushes and restarts playback.
    always_comb begin
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = 1'b0;
        occ_d    = occ_q;
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        valid_d  = valid_q;
        state_d  = state_q;
        if (wr_en && !clear && full_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (clear) begin
            len_d    = '0;
            rd_ptr_d = '0;
            occ_d    = 2'd0;
            valid_d  = 1'b0;
            state_d  = IDLE;
        end else if (wr_acc_s) begin
            len_d    = len_q + (ADDR_W+1)'(1);
            rd_ptr_d = '0;
            occ_d    = 2'd0;
            valid_d  = 1'b0;
            state_d  = PRIME;
        end else begin
            if (pop_s) begin
                buf0_d = buf1_q;
            end else begin
                buf0_d = buf0_q;
            end
            if (push_s) begin
                if (occ_pop_s == 2'd0) begin
                    buf0_d = rd_q;
                end else begin
                    buf1_d = rd_q;
                end
            end else begin
                buf1_d = buf1_q;
            end
            occ_d   = occ_pop_s + {1'b0, push_s};
            valid_d = (occ_d != 2'd0);
            pend_d  = issue_s;
            if (issue_s) begin
                rd_ptr_d = wrap_s ? '0 : rd_ptr_q + ADDR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case (state_q)
                IDLE:    state_d = IDLE;
                PRIME:   state_d = valid_q ? RUN : PRIME;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            pend_q   <= 1'b0;
            occ_q    <= 2'd0;
            buf0_q   <= '0;
            buf1_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            pend_q   <= pend_d;
            occ_q    <= occ_d;
            buf0_q   <= buf0_d;
            buf1_q   <= buf1_d;
            valid_q  <= valid_d;
        end
    end

`ifdef RING_REPLAY_LOOPCNT_EN
    logic        pend_last_q, pend_last_d, last0_q, last0_d, last1_q, last1_d;
    logic [15:0] cnt_q, cnt_d;

    assign loop_cnt = cnt_q;

    // End-of-pass flags travel alongside the buffered samples.
    always_comb begin
        pend_last_d = 1'b0;
        last0_d     = last0_q;
        last1_d     = last1_q;
        cnt_d       = cnt_q;
        if (clear || wr_acc_s) begin
            last0_d = 1'b0;
            last1_d = 1'b0;
            cnt_d   = 16'd0;
        end else begin
            if (pop_s) begin
                last0_d = last1_q;
            end else begin
                last0_d = last0_q;
            end
            if (push_s) begin
                if (occ_pop_s == 2'd0) begin
                    last0_d = pend_last_q;
                end else begin
                    last1_d = pend_last_q;
                end
            end else begin
                last1_d = last1_q;
            end
            pend_last_d = issue_s && wrap_s;
            if (pop_s && last0_q) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Pass-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_last_q <= 1'b0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            pend_last_q <= pend_last_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            cnt_q       <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ring_replay.sv
// Self-checking bench for ring_replay: queue-based replay model checked every cycle plus directed literal sequences.
module tb_ring_replay;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst, clear, wr_en, m_ready;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, full, overflow;
    logic [ADDR_W:0]   length;
`ifdef RING_REPLAY_LOOPCNT_EN
    logic [15:0]       loop_cnt;
`endif

    ring_replay #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .din(din), .wr_en(wr_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .length(length), .full(full),
`ifdef RING_REPLAY_LOOPCNT_EN
        .loop_cnt(loop_cnt),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Model state
    int m_q[$];
    int idx = 0;
    bit m_ovf = 1'b0;
    bit flushed = 1'b1;
    bit stalled = 1'b0;
    int held = 0;
    int since = 0;
    int beats[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("length", {24'd0, length}, m_q.size());
            chk("full", {31'd0, full}, (m_q.size() == DEPTH) ? 1 : 0);
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            if (flushed) chk("valid_after_flush", {31'd0, m_valid}, 0);
            if (stalled) begin
                chk("stall_valid", {31'd0, m_valid}, 1);
                chk("stall_data", {18'd0, m_data}, held);
            end
            if (m_valid) begin
                if (m_q.size() == 0) chk("valid_when_empty", {31'd0, m_valid}, 0);
                else chk("data", {18'd0, m_data}, m_q[idx]);
            end
            if (m_q.size() > 0 && since >= 3) chk("latency", {31'd0, m_valid}, 1);
            if (!rst && m_valid && m_ready) beats.push_back(int'(m_data));

            if (rst) begin
                m_q.delete(); idx = 0; m_ovf = 1'b0; flushed = 1'b1; stalled = 1'b0; since = 0;
            end else if (clear) begin
                m_q.delete(); idx = 0; flushed = 1'b1; stalled = 1'b0; since = 0;
            end else if (wr_en && m_q.size() < DEPTH) begin
                m_q.push_back(int'(din)); idx = 0; flushed = 1'b1; stalled = 1'b0; since = 0;
            end else begin
                if (wr_en) m_ovf = 1'b1;
                flushed = 1'b0;
                if (m_valid && m_ready && m_q.size() > 0) idx = (idx + 1) % m_q.size();
                stalled = m_valid && !m_ready;
                held = int'(m_data);
                since++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v);
        wr_en = 1'b1;
        din = DATA_W'(v);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int c = 0; c < budget && beats.size() < n; c++) step();
        chk("beat_budget", (beats.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic cmp_beats(input string name, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < beats.size()) chk(name, beats[i], exp[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int pat[4];
        int exp_q[$];
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; m_ready = 1'b0; din = '0;
        pat = '{1, 0, 0, 1};
        step();
        mon_en = 1'b1;
        step();
        chk("rst_length", {24'd0, length}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_data", {18'd0, m_data}, 0);
        rst = 1'b0;
        step();

        // Three samples streamed with m_ready high
        m_ready = 1'b1;
        wr(3); wr(7); wr(9);
        beats.delete();
        wait_beats(6, 12);
        cmp_beats("seq_379", '{3, 7, 9, 3, 7, 9});
        chk("len3", {24'd0, length}, 3);

        // Stalls with length 4
        m_ready = 1'b0;
        do_clear();
        wr(1); wr(2); wr(3); wr(4);
        repeat (5) step();
        beats.delete();
        for (int i = 0; i < 16; i++) begin
            m_ready = pat[i % 4][0];
            step();
        end
        m_ready = 1'b0;
        chk("stall_count", beats.size(), 8);
        cmp_beats("stall_seq", '{1, 2, 3, 4, 1, 2, 3, 4});

        // Mid-stream write restarts playback
        do_clear();
        wr(5); wr(6);
        repeat (4) step();
        m_ready = 1'b1;
        repeat (3) step();
        wr(42);
        chk("restart_valid", {31'd0, m_valid}, 0);
        beats.delete();
        wait_beats(6, 16);
        cmp_beats("restart_seq", '{5, 6, 42, 5, 6, 42});

        // Fill to DEPTH, then one dropped write
        m_ready = 1'b0;
        do_clear();
        for (int i = 0; i < DEPTH; i++) wr(i);
        chk("full_before_extra", {31'd0, full}, 1);
        wr(500);
        chk("full", {31'd0, full}, 1);
        chk("overflow_set", {31'd0, overflow}, 1);
        chk("len_full", {24'd0, length}, 128);
        beats.delete();
        m_ready = 1'b1;
        wait_beats(130, 160);
        exp_q.delete();
        for (int i = 0; i < 130; i++) exp_q.push_back(i % DEPTH);
        cmp_beats("full_wrap", exp_q);

        // Clear with simultaneous write
        do_clear();
        for (int i = 1; i <= 5; i++) wr(i);
        repeat (6) step();
        clear = 1'b1; wr_en = 1'b1; din = DATA_W'(99);
        step();
        clear = 1'b0; wr_en = 1'b0;
        chk("clr_len", {24'd0, length}, 0);
        chk("clr_valid", {31'd0, m_valid}, 0);
        chk("clr_ovf_sticky", {31'd0, overflow}, 1);
        wr(11);
        beats.delete();
        wait_beats(4, 12);
        cmp_beats("single_seq", '{11, 11, 11, 11});

        // Pass counting and mid-stream reset
        m_ready = 1'b0;
        do_clear();
        wr(7); wr(8);
        repeat (5) step();
        m_ready = 1'b1;
        beats.delete();
        repeat (10) step();
        m_ready = 1'b0;
        chk("ten_beats", beats.size(), 10);
`ifdef RING_REPLAY_LOOPCNT_EN
        chk("loop_cnt5", {16'd0, loop_cnt}, 5);
`endif
        m_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", {31'd0, m_valid}, 0);
        chk("rst_mid_data", {18'd0, m_data}, 0);
        chk("rst_mid_ovf", {31'd0, overflow}, 0);
`ifdef RING_REPLAY_LOOPCNT_EN
        chk("rst_loop_cnt", {16'd0, loop_cnt}, 0);
`endif
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
